multicycle_sequencer: RTL and testbench
=======================================

// Module: multicycle_sequencer
// PURPOSE
//   FSM that sequences the RV32I datapath over several cycles per instruction.
//   Covers fetch, decode, execute, memory access and writeback. Drives PC/IR
//   enables, mux selects and alu_op into the ALU decoder. Runs a req/ready
//   handshake with the unified instruction/data memory and flags stalled
//   accesses via a wait-cycle timeout.
// PARAMETERS
//   MAX_WAIT  16  cycles mem_req may stay unanswered before bus_error (>=1)
//   WAIT_W    5   width of wait counter; must hold MAX_WAIT
// PORTS
//   clk               in   1  sole clock, rising edge
//   rst_n             in   1  asynchronous, active-low reset
//   opcode            in   7  instruction opcode from IR
//   alu_zero          in   1  ALU zero flag
//   mem_ready         in   1  memory accepted write / returned read data this cycle
//   mem_req           out  1  memory access request
//   mem_we            out  1  write strobe, valid with mem_req
//   adr_src           out  1  0: address=PC, 1: address=ALU result register
//   ir_write          out  1  load IR and old-PC registers
//   pc_write          out  1  PC update (fetch increment or taken branch)
//   reg_write_enable  out  1  register file write
//   alu_src_a         out  2  00 PC, 01 old PC, 10 rs1
//   alu_src_b         out  2  00 rs2, 01 immediate, 10 constant 4
//   result_src        out  2  00 ALU result reg, 01 mem data reg, 10 ALU out
//   alu_op            out  2  00 add(load/store), 01 sub(branch), 10 funct-decode
//   bus_error         out  1  sticky: memory timeout occurred
//   illegal_instr     out  1  sticky: unsupported opcode (TRAP_ILLEGAL_EN only)
// BEHAVIOUR
//   Reset (async, rst_n=0): state=FETCH, wait_cnt=0, every output 0.
//   Outputs are Moore (state decode) except pc_write in BEQ and ir_write/pc_write
//     in FETCH, which qualify on inputs as noted.
//   FETCH: mem_req=1, adr_src=0, alu_src_a=00, alu_src_b=10, alu_op=00,
//     result_src=10. On mem_ready: ir_write=1, pc_write=1 (same cycle) -> DECODE.
//   DECODE: alu_src_a=01, alu_src_b=01, alu_op=00 (branch target). By opcode:
//     0000011/0100011 -> MEM_ADR; 0110011 -> EXEC_R; 1100011 -> BEQ; else ILLEGAL.
//   MEM_ADR: alu_src_a=10, alu_src_b=01, alu_op=00. load -> MEM_RD, store -> MEM_WR.
//   MEM_RD: mem_req=1, adr_src=1; mem_ready -> MEM_WB.
//   MEM_WB: result_src=01, reg_write_enable=1 -> FETCH.
//   MEM_WR: mem_req=1, mem_we=1, adr_src=1; mem_ready -> FETCH.
//   EXEC_R: alu_src_a=10, alu_src_b=00, alu_op=10 -> ALU_WB.
//   ALU_WB: result_src=00, reg_write_enable=1 -> FETCH.
//   BEQ: alu_src_a=10, alu_src_b=00, alu_op=01, result_src=00, pc_write=alu_zero
//     -> FETCH. One cycle, whether or not taken.
//   Latency: load 5, store 4, R-type 4, beq 3 cycles, with zero-wait memory.
//   Handshake: mem_req, mem_we and adr_src stay stable until the mem_ready cycle.
//     mem_ready with mem_req=0 is ignored. No new request in the ready cycle.
//   Timeout: wait_cnt clears on state entry and increments each mem_req cycle
//     without mem_ready. When wait_cnt reaches MAX_WAIT with no mem_ready:
//     set bus_error, drop mem_req, go to HALT. mem_ready in that same cycle
//     wins (normal completion).
//   HALT: all outputs 0 except sticky flags. Only reset leaves HALT.
//   Sticky flags clear only on reset.
//   Reset mid-access: mem_req drops asynchronously and no partial writeback occurs.
// CONFIGURATION
//   TRAP_ILLEGAL_EN defined: ILLEGAL sets illegal_instr -> HALT.
//   TRAP_ILLEGAL_EN undefined: ILLEGAL is a 1-cycle NOP -> FETCH.
//     illegal_instr is tied 0.
// TESTING
//   lw (0000011), mem_ready same cycle as each req -> ir_write@1, one
//     reg_write_enable with result_src=01, back in FETCH after 5 cycles.
//   sw (0100011), mem_ready delayed 3 cycles in MEM_WR -> mem_req/mem_we/adr_src=1
//     held 4 cycles, no reg_write_enable.
//   beq with alu_zero=1, then again with alu_zero=0 -> pc_write pulses exactly
//     once in BEQ in the first case and not in the second.
//   mem_ready never asserted in FETCH, MAX_WAIT=16 -> bus_error=1 after 16 wait
//     cycles, mem_req=0, HALT persists until rst_n pulses low.
//   opcode 0x7F -> with TRAP_ILLEGAL_EN: illegal_instr=1 and halt; without: FETCH
//     re-entered 2 cycles after DECODE.
//   rst_n low during MEM_WR wait -> mem_req/mem_we drop immediately. After release:
//     FETCH with all flags 0.

Source files
------------

// File: rtl/multicycle_sequencer.sv
// -----------------------------------------------------------------------------
// multicycle_sequencer
//   Control FSM for a multi-cycle RV32I datapath. Each instruction passes
//   through fetch, decode and then execute / memory / writeback states. The
//   block drives the PC/IR enables, datapath mux selects and the alu_op code
//   for the ALU decoder. It also runs a req/ready handshake with the unified
//   instruction/data memory and aborts to HALT when an access stays
//   unanswered for MAX_WAIT cycles.
//
//   Optional feature macro: TRAP_ILLEGAL_EN
//     defined   : an unsupported opcode sets sticky illegal_instr and halts
//     undefined : an unsupported opcode is a one-cycle NOP, illegal_instr = 0
//
// Ports
//   clk               in   rising-edge clock
//   rst_n             in   asynchronous active-low reset
//   opcode[6:0]       in   opcode field of the instruction register
//   alu_zero          in   ALU zero flag (branch compare result)
//   mem_ready         in   memory accepted the write / returned read data
//   mem_req           out  memory access request
//   mem_we            out  memory write strobe, valid with mem_req
//   adr_src           out  memory address select: 0 PC, 1 ALU result register
//   ir_write          out  load IR and old-PC registers
//   pc_write          out  PC update (fetch increment or taken branch)
//   reg_write_enable  out  register file write
//   alu_src_a[1:0]    out  00 PC, 01 old PC, 10 rs1
//   alu_src_b[1:0]    out  00 rs2, 01 immediate, 10 constant 4
//   result_src[1:0]   out  00 ALU result reg, 01 mem data reg, 10 ALU out
//   alu_op[1:0]       out  00 add, 01 sub, 10 decode funct fields
//   bus_error         out  sticky: a memory access timed out
//   illegal_instr     out  sticky: unsupported opcode (trap build only)
// -----------------------------------------------------------------------------
module multicycle_sequencer #(
    parameter int MAX_WAIT = 16,
    parameter int WAIT_W   = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic       alu_zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       adr_src,
    output logic       ir_write,
    output logic       pc_write,
    output logic       reg_write_enable,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] result_src,
    output logic [1:0] alu_op,
    output logic       bus_error,
    output logic       illegal_instr
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    // The timeout fires on the MAX_WAIT-th unanswered request cycle, i.e.
    // when the increment would bring the counter to MAX_WAIT.
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);
    localparam logic [WAIT_W-1:0] WAIT_ONE  = {{(WAIT_W-1){1'b0}}, 1'b1};

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEM_ADR = 4'd2,
        S_MEM_RD  = 4'd3,
        S_MEM_WB  = 4'd4,
        S_MEM_WR  = 4'd5,
        S_EXEC_R  = 4'd6,
        S_ALU_WB  = 4'd7,
        S_BEQ     = 4'd8,
        S_ILLEGAL = 4'd9,
        S_HALT    = 4'd10
    } state_t;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       adr_src;
        logic       reg_write_enable;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] result_src;
        logic [1:0] alu_op;
    } ctrl_t;

    // Moore control word of a state; registered from the next state so the
    // outputs change together with the state register.
    function automatic ctrl_t decode_ctrl(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.mem_req    = 1'b1;
                c.alu_src_b  = 2'b10;
                c.result_src = 2'b10;
            end
            S_DECODE: begin
                c.alu_src_a = 2'b01;
                c.alu_src_b = 2'b01;
            end
            S_MEM_ADR: begin
                c.alu_src_a = 2'b10;
                c.alu_src_b = 2'b01;
            end
            S_MEM_RD: begin
                c.mem_req = 1'b1;
                c.adr_src = 1'b1;
            end
            S_MEM_WB: begin
                c.result_src       = 2'b01;
                c.reg_write_enable = 1'b1;
            end
            S_MEM_WR: begin
                c.mem_req = 1'b1;
                c.mem_we  = 1'b1;
                c.adr_src = 1'b1;
            end
            S_EXEC_R: begin
                c.alu_src_a = 2'b10;
                c.alu_op    = 2'b10;
            end
            S_ALU_WB: begin
                c.reg_write_enable = 1'b1;
            end
            S_BEQ: begin
                c.alu_src_a = 2'b10;
                c.alu_op    = 2'b01;
            end
            default: begin
                c = '0;
            end
        endcase
        return c;
    endfunction

    state_t            state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    ctrl_t             ctrl_q;
    logic              bus_error_q;
    logic              mem_done_s;
    logic              mem_stall_s;
    logic              mem_timeout_s;

    // Handshake qualifiers use the registered request, so mem_ready is
    // ignored whenever mem_req is low (including the cycle after reset).
    always_comb begin
        mem_done_s    = ctrl_q.mem_req & mem_ready;
        mem_stall_s   = ctrl_q.mem_req & ~mem_ready;
        mem_timeout_s = mem_stall_s & (wait_q == WAIT_LAST);
    end

    // Next-state and wait-counter logic.
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        case (state_q)
            S_FETCH: begin
                if (mem_done_s) begin
                    state_d = S_DECODE;
                end else if (mem_timeout_s) begin
                    state_d = S_HALT;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_DECODE: begin
                case (opcode)
                    OP_LOAD, OP_STORE: state_d = S_MEM_ADR;
                    OP_RTYPE:          state_d = S_EXEC_R;
                    OP_BRANCH:         state_d = S_BEQ;
                    default:           state_d = S_ILLEGAL;
                endcase
            end
            S_MEM_ADR: begin
                if (opcode == OP_LOAD) begin
                    state_d = S_MEM_RD;
                end else begin
                    state_d = S_MEM_WR;
                end
            end
            S_MEM_RD: begin
                if (mem_done_s) begin
                    state_d = S_MEM_WB;
                end else if (mem_timeout_s) begin
                    state_d = S_HALT;
                end else begin
                    state_d = S_MEM_RD;
                end
            end
            S_MEM_WR: begin
                if (mem_done_s) begin
                    state_d = S_FETCH;
                end else if (mem_timeout_s) begin
                    state_d = S_HALT;
                end else begin
                    state_d = S_MEM_WR;
                end
            end
            S_MEM_WB:  state_d = S_FETCH;
            S_EXEC_R:  state_d = S_ALU_WB;
            S_ALU_WB:  state_d = S_FETCH;
            S_BEQ:     state_d = S_FETCH;
`ifdef TRAP_ILLEGAL_EN
            S_ILLEGAL: state_d = S_HALT;
`else
            S_ILLEGAL: state_d = S_FETCH;
`endif
            S_HALT:    state_d = S_HALT;
            default:   state_d = S_HALT;
        endcase

        // Count unanswered request cycles; restart on every state change.
        if (state_d != state_q) begin
            wait_d = '0;
        end else if (mem_stall_s) begin
            wait_d = wait_q + WAIT_ONE;
        end else begin
            wait_d = wait_q;
        end
    end

    // State, wait counter, registered control word and sticky bus error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_FETCH;
            wait_q      <= '0;
            ctrl_q      <= '0;
            bus_error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            ctrl_q  <= decode_ctrl(state_d);
            if (mem_timeout_s) begin
                bus_error_q <= 1'b1;
            end
        end
    end

`ifdef TRAP_ILLEGAL_EN
    logic illegal_q;

    // Sticky illegal-instruction flag, set as the FSM leaves ILLEGAL.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_q <= 1'b0;
        end else if (state_q == S_ILLEGAL) begin
            illegal_q <= 1'b1;
        end
    end

    assign illegal_instr = illegal_q;
`else
    assign illegal_instr = 1'b0;
`endif

    // IR/PC enables must act in the cycle the memory answers, so they are
    // qualified directly on the inputs rather than registered.
    assign ir_write = (state_q == S_FETCH) & mem_done_s;
    assign pc_write = ir_write | ((state_q == S_BEQ) & alu_zero);

    assign mem_req          = ctrl_q.mem_req;
    assign mem_we           = ctrl_q.mem_we;
    assign adr_src          = ctrl_q.adr_src;
    assign reg_write_enable = ctrl_q.reg_write_enable;
    assign alu_src_a        = ctrl_q.alu_src_a;
    assign alu_src_b        = ctrl_q.alu_src_b;
    assign result_src       = ctrl_q.result_src;
    assign alu_op           = ctrl_q.alu_op;
    assign bus_error        = bus_error_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// -----------------------------------------------------------------------------
// tb_multicycle_sequencer
//   Directed bench for multicycle_sequencer. A table of per-cycle vectors
//   walks lw / R-type / beq (taken and not taken); hand-written sequences
//   cover the delayed store, memory timeout, ready on the last wait cycle,
//   illegal opcode and reset in the middle of a store.
//   Output vector layout (16 bits):
//   {mem_req, mem_we, adr_src, ir_write, pc_write, reg_write_enable,
//    alu_src_a[1:0], alu_src_b[1:0], result_src[1:0], alu_op[1:0],
//    bus_error, illegal_instr}
// -----------------------------------------------------------------------------
module tb_multicycle_sequencer;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_RT  = 7'b0110011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_BAD = 7'b1111111;

    logic       clk;
    logic       rst_n;
    logic [6:0] opcode;
    logic       alu_zero;
    logic       mem_ready;
    logic       mem_req;
    logic       mem_we;
    logic       adr_src;
    logic       ir_write;
    logic       pc_write;
    logic       reg_write_enable;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
    logic [1:0] alu_op;
    logic       bus_error;
    logic       illegal_instr;
    logic [15:0] obs;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [6:0]  op;
        logic        z;
        logic        rdy;
        logic [15:0] exp;
    } vec_t;

    vec_t vt [15];

    logic [15:0] X_ZERO, X_FETCH, X_FETCH_RDY, X_DECODE, X_MEM_ADR, X_MEM_RD;
    logic [15:0] X_MEM_WB, X_MEM_WR, X_EXEC_R, X_ALU_WB, X_BEQ_T, X_BEQ_NT;
    logic [15:0] X_HALT_BE, X_HALT_ILL;

    multicycle_sequencer #(
        .MAX_WAIT(16),
        .WAIT_W  (5)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .opcode          (opcode),
        .alu_zero        (alu_zero),
        .mem_ready       (mem_ready),
        .mem_req         (mem_req),
        .mem_we          (mem_we),
        .adr_src         (adr_src),
        .ir_write        (ir_write),
        .pc_write        (pc_write),
        .reg_write_enable(reg_write_enable),
        .alu_src_a       (alu_src_a),
        .alu_src_b       (alu_src_b),
        .result_src      (result_src),
        .alu_op          (alu_op),
        .bus_error       (bus_error),
        .illegal_instr   (illegal_instr)
    );

    assign obs = {mem_req, mem_we, adr_src, ir_write, pc_write, reg_write_enable,
                  alu_src_a, alu_src_b, result_src, alu_op, bus_error, illegal_instr};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] mk(input logic req, input logic we, input logic adr,
                                       input logic irw, input logic pcw, input logic rwe,
                                       input logic [1:0] a, input logic [1:0] b,
                                       input logic [1:0] rs, input logic [1:0] op,
                                       input logic be, input logic ill);
        return {req, we, adr, irw, pcw, rwe, a, b, rs, op, be, ill};
    endfunction

    function automatic vec_t row(input logic [6:0] op, input logic z, input logic rdy,
                                 input logic [15:0] exp);
        vec_t v;
        v.op  = op;
        v.z   = z;
        v.rdy = rdy;
        v.exp = exp;
        return v;
    endfunction

    task automatic chk(input string name, input logic [15:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, obs, exp);
        end
    endtask

    // Called at posedge+1: apply inputs, settle, then caller samples.
    task automatic drive(input logic [6:0] op, input logic z, input logic rdy);
        opcode    = op;
        alu_zero  = z;
        mem_ready = rdy;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reset pulse with mem_ready held high to show it is ignored, then the
    // idle cycle before the first registered FETCH request.
    task automatic do_reset(input string tag);
        opcode    = OP_LW;
        alu_zero  = 1'b1;
        mem_ready = 1'b1;
        rst_n     = 1'b0;
        #1;
        chk({tag, " in reset"}, X_ZERO);
        tick();
        rst_n = 1'b1;
        #1;
        chk({tag, " idle after release"}, X_ZERO);
        tick();
    endtask

    initial begin
        X_ZERO      = mk(0,0,0,0,0,0,2'b00,2'b00,2'b00,2'b00,0,0);
        X_FETCH     = mk(1,0,0,0,0,0,2'b00,2'b10,2'b10,2'b00,0,0);
        X_FETCH_RDY = mk(1,0,0,1,1,0,2'b00,2'b10,2'b10,2'b00,0,0);
        X_DECODE    = mk(0,0,0,0,0,0,2'b01,2'b01,2'b00,2'b00,0,0);
        X_MEM_ADR   = mk(0,0,0,0,0,0,2'b10,2'b01,2'b00,2'b00,0,0);
        X_MEM_RD    = mk(1,0,1,0,0,0,2'b00,2'b00,2'b00,2'b00,0,0);
        X_MEM_WB    = mk(0,0,0,0,0,1,2'b00,2'b00,2'b01,2'b00,0,0);
        X_MEM_WR    = mk(1,1,1,0,0,0,2'b00,2'b00,2'b00,2'b00,0,0);
        X_EXEC_R    = mk(0,0,0,0,0,0,2'b10,2'b00,2'b00,2'b10,0,0);
        X_ALU_WB    = mk(0,0,0,0,0,1,2'b00,2'b00,2'b00,2'b00,0,0);
        X_BEQ_T     = mk(0,0,0,0,1,0,2'b10,2'b00,2'b00,2'b01,0,0);
        X_BEQ_NT    = mk(0,0,0,0,0,0,2'b10,2'b00,2'b00,2'b01,0,0);
        X_HALT_BE   = mk(0,0,0,0,0,0,2'b00,2'b00,2'b00,2'b00,1,0);
        X_HALT_ILL  = mk(0,0,0,0,0,0,2'b00,2'b00,2'b00,2'b00,0,1);

        // lw, zero-wait memory: 5 cycles
        vt[0]  = row(OP_LW, 1'b0, 1'b1, X_FETCH_RDY);
        vt[1]  = row(OP_LW, 1'b0, 1'b0, X_DECODE);
        vt[2]  = row(OP_LW, 1'b0, 1'b0, X_MEM_ADR);
        vt[3]  = row(OP_LW, 1'b0, 1'b1, X_MEM_RD);
        vt[4]  = row(OP_LW, 1'b0, 1'b0, X_MEM_WB);
        // R-type: 4 cycles, ready in DECODE is ignored
        vt[5]  = row(OP_RT, 1'b0, 1'b1, X_FETCH_RDY);
        vt[6]  = row(OP_RT, 1'b0, 1'b1, X_DECODE);
        vt[7]  = row(OP_RT, 1'b0, 1'b0, X_EXEC_R);
        vt[8]  = row(OP_RT, 1'b1, 1'b0, X_ALU_WB);
        // beq taken, then not taken: pc_write only in the taken BEQ cycle
        vt[9]  = row(OP_BR, 1'b1, 1'b1, X_FETCH_RDY);
        vt[10] = row(OP_BR, 1'b1, 1'b0, X_DECODE);
        vt[11] = row(OP_BR, 1'b1, 1'b0, X_BEQ_T);
        vt[12] = row(OP_BR, 1'b0, 1'b1, X_FETCH_RDY);
        vt[13] = row(OP_BR, 1'b0, 1'b0, X_DECODE);
        vt[14] = row(OP_BR, 1'b0, 1'b1, X_BEQ_NT);

        rst_n     = 1'b0;
        opcode    = 7'b0000000;
        alu_zero  = 1'b0;
        mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset state", X_ZERO);
        rst_n = 1'b1;
        #1;
        chk("idle after first release", X_ZERO);
        tick();

        for (int i = 0; i < 15; i++) begin
            drive(vt[i].op, vt[i].z, vt[i].rdy);
            chk($sformatf("vec[%0d]", i), vt[i].exp);
            tick();
        end

        // sw with mem_ready delayed 3 cycles in MEM_WR
        drive(OP_SW, 1'b0, 1'b1); chk("sw fetch", X_FETCH_RDY); tick();
        drive(OP_SW, 1'b0, 1'b0); chk("sw decode", X_DECODE); tick();
        drive(OP_SW, 1'b0, 1'b0); chk("sw mem_adr", X_MEM_ADR); tick();
        for (int i = 0; i < 4; i++) begin
            drive(OP_SW, 1'b0, (i == 3));
            chk($sformatf("sw mem_wr hold %0d", i), X_MEM_WR);
            tick();
        end

        // Timeout: FETCH never answered; 16 request cycles then HALT
        for (int i = 0; i < 16; i++) begin
            drive(OP_LW, 1'b0, 1'b0);
            chk($sformatf("timeout wait %0d", i), X_FETCH);
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            drive(OP_LW, 1'b1, 1'b1);
            chk($sformatf("halt after timeout %0d", i), X_HALT_BE);
            tick();
        end
        do_reset("reset from halt");

        // mem_ready on the 16th wait cycle wins over the timeout
        for (int i = 0; i < 15; i++) begin
            drive(OP_BAD, 1'b0, 1'b0);
            chk($sformatf("late ready wait %0d", i), X_FETCH);
            tick();
        end
        drive(OP_BAD, 1'b0, 1'b1); chk("ready on last wait cycle", X_FETCH_RDY); tick();
        drive(OP_BAD, 1'b0, 1'b0); chk("decode after late ready", X_DECODE); tick();
        drive(OP_BAD, 1'b0, 1'b1); chk("illegal state", X_ZERO); tick();
`ifdef TRAP_ILLEGAL_EN
        for (int i = 0; i < 3; i++) begin
            drive(OP_LW, 1'b1, 1'b1);
            chk($sformatf("halt after illegal %0d", i), X_HALT_ILL);
            tick();
        end
`else
        drive(OP_LW, 1'b0, 1'b0); chk("fetch after illegal nop", X_FETCH); tick();
`endif
        do_reset("reset after illegal");

        // Reset in the middle of a stalled store
        drive(OP_SW, 1'b0, 1'b1); chk("rst-sw fetch", X_FETCH_RDY); tick();
        drive(OP_SW, 1'b0, 1'b0); chk("rst-sw decode", X_DECODE); tick();
        drive(OP_SW, 1'b0, 1'b0); chk("rst-sw mem_adr", X_MEM_ADR); tick();
        drive(OP_SW, 1'b0, 1'b0); chk("rst-sw mem_wr", X_MEM_WR); tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("async drop of mem_req/mem_we", X_ZERO);
        tick();
        rst_n = 1'b1;
        #1;
        chk("idle after mid-access reset", X_ZERO);
        tick();
        drive(OP_LW, 1'b0, 1'b0); chk("fetch with flags clear", X_FETCH); tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
